// File: rtl/pipe_pkg.sv
// Shared types for the RV32I pipeline hazard control.
// Stall/flush bundle and stall FSM state encoding.
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } stall_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushD;
    logic flushE;
    logic flushW;
  } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush control for load-use, taken branches and
// variable-latency data memory, with wait timeout and perf counters.
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic             MemErr,
  output logic [CNT_W-1:0] LuCnt,
  output logic [CNT_W-1:0] BrCnt,
  output logic [CNT_W-1:0] MwCnt
);

  import pipe_pkg::*;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  stall_state_e state;
  logic [7:0]   waitCnt;
  ctrl_t        ctrl;
  logic         lwHaz;
  logic         memMiss;
  logic         luInc;
  logic         brInc;
  logic         mwInc;
  logic         memTo;
  logic         cntClr;

  assign lwHaz = ResultSrcE0 && (RdE != REG_ZERO) &&
                 ((RdE == Rs1D) || (RdE == Rs2D));
  assign memMiss = MemReqM && !MemReadyM;
  assign cntClr  = !rst_n;

  always_comb begin
    ctrl  = '0;
    memTo = 1'b0;
    luInc = 1'b0;
    brInc = 1'b0;
    mwInc = 1'b0;
    if (rst_n) begin
      unique case (state)
        RUN: begin
          if (memMiss) begin
            ctrl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
          end else if (PCSrcE) begin
            ctrl.flushD = 1'b1;
            ctrl.flushE = 1'b1;
            brInc       = 1'b1;
          end else if (lwHaz) begin
            ctrl.stallF = 1'b1;
            ctrl.stallD = 1'b1;
            ctrl.flushE = 1'b1;
            luInc       = 1'b1;
          end
        end
        MEM_WAIT: begin
          // Full freeze; branch and load-use wait for release
          ctrl  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
          mwInc = 1'b1;
          memTo = !MemReadyM && (waitCnt == TO_LAST);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      waitCnt <= '0;
      MemErr  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (memMiss) begin
            state   <= MEM_WAIT;
            waitCnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (MemReadyM || memTo) begin
            state   <= RUN;
            waitCnt <= '0;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
          if (memTo) MemErr <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign StallF     = ctrl.stallF;
  assign StallD     = ctrl.stallD;
  assign StallE     = ctrl.stallE;
  assign StallM     = ctrl.stallM;
  assign FlushD     = ctrl.flushD;
  assign FlushE     = ctrl.flushE;
  assign FlushW     = ctrl.flushW;
  assign MemTimeout = memTo;

  sat_counter #(.CNT_W(CNT_W)) uLuCnt (
    .clk (clk),
    .clr (cntClr),
    .inc (luInc),
    .cnt (LuCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uBrCnt (
    .clk (clk),
    .clr (cntClr),
    .inc (brInc),
    .cnt (BrCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uMwCnt (
    .clk (clk),
    .clr (cntClr),
    .inc (mwInc),
    .cnt (MwCnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed scoreboard bench for pipeline_stall_ctrl.
// Built with MEM_TIMEOUT=4 and CNT_W=4 so timeout and saturation are short.
module tb_pipeline_stall_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    Rs1D = '0;
  logic [4:0]    Rs2D = '0;
  logic [4:0]    RdE = '0;
  logic          ResultSrcE0 = 1'b0;
  logic          PCSrcE = 1'b0;
  logic          MemReqM = 1'b0;
  logic          MemReadyM = 1'b0;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW;
  logic          MemTimeout, MemErr;
  logic [CW-1:0] LuCnt, BrCnt, MwCnt;

  pipeline_stall_ctrl #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .RdE         (RdE),
    .ResultSrcE0 (ResultSrcE0),
    .PCSrcE      (PCSrcE),
    .MemReqM     (MemReqM),
    .MemReadyM   (MemReadyM),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .MemTimeout  (MemTimeout),
    .MemErr      (MemErr),
    .LuCnt       (LuCnt),
    .BrCnt       (BrCnt),
    .MwCnt       (MwCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       id;
    logic [3:0] st;
    logic [2:0] fl;
    logic     to;
    logic     err;
    int       lu;
    int       br;
    int       mw;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   rowId = 0;

  task automatic chk(input int id, input string nm,
                     input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL row%0d %s got %0d exp %0d", id, nm, got, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.id, "stall", int'({StallF, StallD, StallE, StallM}), int'(e.st));
      chk(e.id, "flush", int'({FlushD, FlushE, FlushW}), int'(e.fl));
      chk(e.id, "timeout", int'(MemTimeout), int'(e.to));
      chk(e.id, "err", int'(MemErr), int'(e.err));
      chk(e.id, "lucnt", int'(LuCnt), e.lu);
      chk(e.id, "brcnt", int'(BrCnt), e.br);
      chk(e.id, "mwcnt", int'(MwCnt), e.mw);
    end
  end

  // One cycle: drive inputs after the edge, push the expected response
  task automatic v(input logic rst, input int rs1, input int rs2,
                   input int rd, input logic ld, input logic pc,
                   input logic req, input logic rdy,
                   input logic [3:0] st, input logic [2:0] fl,
                   input logic to, input logic err,
                   input int lu, input int br, input int mw);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = rst;
    Rs1D        = 5'(rs1);
    Rs2D        = 5'(rs2);
    RdE         = 5'(rd);
    ResultSrcE0 = ld;
    PCSrcE      = pc;
    MemReqM     = req;
    MemReadyM   = rdy;
    e.id  = rowId;
    e.st  = st;
    e.fl  = fl;
    e.to  = to;
    e.err = err;
    e.lu  = lu;
    e.br  = br;
    e.mw  = mw;
    q.push_back(e);
    rowId++;
  endtask

  initial begin
    // reset state
    v(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0, 0, 0, 0, 0);
    // load-use: one bubble, then clear
    v(1, 5, 0, 5, 1, 0, 0, 0, 4'b1100, 3'b010, 0, 0, 0, 0, 0);
    v(1, 5, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0, 0, 1, 0, 0);
    // rd = x0 never stalls
    v(1, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 3'b000, 0, 0, 1, 0, 0);
    // rd matches both sources: one event
    v(1, 7, 7, 7, 1, 0, 0, 0, 4'b1100, 3'b010, 0, 0, 1, 0, 0);
    v(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0, 0, 2, 0, 0);
    // branch beats coincident load-use
    v(1, 5, 0, 5, 1, 1, 0, 0, 4'b0000, 3'b110, 0, 0, 2, 0, 0);
    v(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0, 0, 2, 1, 0);
    // memory wait, branch held in E throughout
    v(1, 0, 0, 0, 0, 1, 1, 0, 4'b1111, 3'b001, 0, 0, 2, 1, 0);
    v(1, 0, 0, 0, 0, 1, 1, 0, 4'b1111, 3'b001, 0, 0, 2, 1, 0);
    v(1, 0, 0, 0, 0, 1, 1, 0, 4'b1111, 3'b001, 0, 0, 2, 1, 1);
    v(1, 0, 0, 0, 0, 1, 1, 1, 4'b1111, 3'b001, 0, 0, 2, 1, 2);
    v(1, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 3'b110, 0, 0, 2, 1, 3);
    v(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0, 0, 2, 2, 3);
    // zero-wait access
    v(1, 0, 0, 0, 0, 0, 1, 1, 4'b0000, 3'b000, 0, 0, 2, 2, 3);
    // timeout on the 4th stalled cycle
    v(1, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 3'b001, 0, 0, 2, 2, 3);
    v(1, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 3'b001, 0, 0, 2, 2, 3);
    v(1, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 3'b001, 0, 0, 2, 2, 4);
    v(1, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 3'b001, 1, 0, 2, 2, 5);
    v(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0, 1, 2, 2, 6);
    v(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0, 1, 2, 2, 6);
    // reset during the second wait cycle
    v(1, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 3'b001, 0, 1, 2, 2, 6);
    v(1, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 3'b001, 0, 1, 2, 2, 6);
    v(0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b000, 0, 1, 2, 2, 7);
    v(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0, 0, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0, 0, 0, 0, 0);
    // 20 load-use events saturate a 4-bit counter at 15
    for (int k = 0; k < 20; k++) begin
      v(1, 9, 3, 9, 1, 0, 0, 0, 4'b1100, 3'b010, 0, 0,
        (k > 15) ? 15 : k, 0, 0);
    end
    v(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0, 0, 15, 0, 0);
    v(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0, 0, 15, 0, 0);
    // drain the scoreboard with a bound
    for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Stall/flush half of hazard handling for the 5-stage RV32I pipeline. The existing forwarding logic resolves RAW hazards by bypass; this block resolves the cases bypass cannot.
- Cases handled: load-use, taken branch/jump, and data memory accesses with variable latency.
- Drives StallF/StallD/StallE/StallM and FlushD/FlushE/FlushW into the pipeline registers.
- Tracks memory-wait in an FSM with timeout, and keeps saturating perf counters.

Parameters:
- MEM_TIMEOUT, 64, maximum cycles spent in MEM_WAIT before abort; legal range 2..255.
- CNT_W, 16, width of each perf counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- Rs1D  in  5  rs1 of instruction in Decode
- Rs2D  in  5  rs2 of instruction in Decode
- RdE  in  5  rd of instruction in Execute
- ResultSrcE0  in  1  Execute instruction is a load
- PCSrcE  in  1  branch/jump taken in Execute
- MemReqM  in  1  Memory-stage instruction accesses data memory
- MemReadyM  in  1  data memory response valid this cycle
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1 each  clear the corresponding register to a bubble
- MemTimeout  out  1  one-cycle pulse on wait abort
- MemErr  out  1  sticky error flag, cleared only by reset
- LuCnt, BrCnt, MwCnt  out  CNT_W each  load-use events, branch flushes, memory-wait cycles

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=RUN, wait_cnt=0, all counters=0, MemErr=0.
  - All stall/flush outputs and MemTimeout are 0 while rst_n=0.
- lwHaz = ResultSrcE0 & (RdE!=0) & ((RdE==Rs1D)|(RdE==Rs2D)).
- States are RUN and MEM_WAIT. Outputs are combinational from state and inputs.
- RUN, evaluated in priority order:
  1. MemReqM & !MemReadyM: StallF=StallD=StallE=StallM=1, FlushW=1. No other flush. Next state MEM_WAIT, wait_cnt<=1.
  2. else PCSrcE: FlushD=FlushE=1, no stall, BrCnt++. Any coincident lwHaz is ignored; the branch wins.
  3. else lwHaz: StallF=StallD=1, FlushE=1, LuCnt++. Bubble latency is exactly one cycle; lwHaz drops once the load reaches M.
  4. else all outputs 0.
  - MemReqM & MemReadyM in the same cycle is zero-wait: no stall.
- MEM_WAIT:
  - Every cycle: F/D/E/M stalled, FlushW=1, MwCnt++.
  - PCSrcE and lwHaz are masked; the branch stays frozen in E and is acted on the cycle after release.
  - On MemReadyM=1: outputs this cycle are still the full freeze. Next state RUN, wait_cnt<=0. The following cycle runs the RUN rules on the unfrozen pipeline.
  - On MemReadyM=0 and wait_cnt==MEM_TIMEOUT-1: MemTimeout=1 this cycle, MemErr<=1, next state RUN. The pipeline then proceeds.
  - Otherwise wait_cnt++.
- Counters saturate at all-ones and never wrap.
- Reset mid-wait: on the next edge with rst_n=0, state goes to RUN and all outputs are 0 immediately. No residual stall.
- Rd=x0 never triggers a load-use stall.
- A load whose RdE matches both Rs1D and Rs2D counts as one event.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum (RUN=1'b0, MEM_WAIT=1'b1);
  - the REG_ZERO=5'd0 constant;
  - a ctrl_t bundle of stall/flush bits, for reuse by the pipeline register modules.
- One sub-module, sat_counter (CNT_W wide; inc and clr inputs), instantiated three times.
- FSM, wait counter and priority logic stay in the top module.

Test Plan:
1. Load-use: lw x5 in E (ResultSrcE0=1, RdE=5), Rs1D=5 -> one cycle of StallF=StallD=FlushE=1, then clear; LuCnt=1. Repeat with RdE=0 -> no stall.
2. Branch: PCSrcE=1 for one cycle, with lwHaz also true -> FlushD=FlushE=1, no stall; BrCnt=1, LuCnt unchanged.
3. Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> four cycles of all four stalls plus FlushW, then RUN; MwCnt=3. PCSrcE held 1 throughout -> FlushD/FlushE only on the cycle after release.
4. Timeout with MEM_TIMEOUT=4 and MemReadyM stuck 0 -> MemTimeout pulses on the 4th stalled cycle, MemErr=1 and stays 1, state returns to RUN.
5. Reset mid-wait: rst_n=0 during cycle 2 of MEM_WAIT -> next cycle all outputs 0, counters 0, MemErr=0. After release with an idle stimulus, no stall.
6. Saturation with CNT_W=4: 20 consecutive load-use events -> LuCnt=15 and holds.
